audio_expander: RTL

- Downward expander / noise gate, the inverse of the team's output compressor. Takes 16-bit stereo samples from the mixer and applies a hysteretic, hold-timed gate with ramped attack and release gain. Produces 24-bit samples for the DAC/HDMI audio path.
- Processes one sample per sample_valid_i strobe, through a fixed 3-cycle pipeline.

---
 rtl/audio_dyn_pkg.sv | 30 +++
 rtl/audio_expander_if.sv | 31 +++
 rtl/audio_envelope_peak.sv | 48 ++++
 rtl/audio_expander.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_dyn_pkg.sv
// Shared types and helpers for the audio dynamics blocks (expander, compressor).
//   gate_state_t : gate FSM states
//   GAIN_*       : Q1.16 gain format (65536 = unity)
//   sat_signed   : clamp a signed value to a given two's-complement width
package audio_dyn_pkg;

  typedef enum logic [2:0] {
    CLOSED,
    OPENING,
    OPEN,
    HOLD,
    CLOSING
  } gate_state_t;

  localparam int unsigned GAIN_FRAC  = 16;
  localparam int unsigned GAIN_UNITY = 65536;
  localparam int unsigned GAIN_WIDTH = 17;

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/audio_expander_if.sv
// Sample bus of the audio expander.
//   master : drives enable_i, sample_valid_i, audio_in_l/r; observes results
//   slave  : the expander; drives audio_out_l/r, sample_valid_o, gate_open_o, gain_o
interface audio_expander_if
  import audio_dyn_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 24
);

  logic                           enable_i;
  logic                           sample_valid_i;
  logic signed [INPUT_WIDTH-1:0]  audio_in_l;
  logic signed [INPUT_WIDTH-1:0]  audio_in_r;
  logic signed [OUTPUT_WIDTH-1:0] audio_out_l;
  logic signed [OUTPUT_WIDTH-1:0] audio_out_r;
  logic                           sample_valid_o;
  logic                           gate_open_o;
  logic [GAIN_WIDTH-1:0]          gain_o;

  modport master (
    output enable_i, sample_valid_i, audio_in_l, audio_in_r,
    input  audio_out_l, audio_out_r, sample_valid_o, gate_open_o, gain_o
  );

  modport slave (
    input  enable_i, sample_valid_i, audio_in_l, audio_in_r,
    output audio_out_l, audio_out_r, sample_valid_o, gate_open_o, gain_o
  );

endinterface

// File: rtl/audio_envelope_peak.sv
// Stereo peak envelope follower: instant attack, exponential decay.
//   clk_i, reset_n_i : clock, async active-low reset
//   valid            : new sample on in_l/in_r this cycle
//   in_l, in_r       : signed samples
//   env              : registered envelope after the latest sample (unsigned, INPUT_WIDTH-1)
module audio_envelope_peak #(
  parameter int unsigned INPUT_WIDTH = 16,
  parameter int unsigned ENV_SHIFT   = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          valid,
  input  logic signed [INPUT_WIDTH-1:0] in_l,
  input  logic signed [INPUT_WIDTH-1:0] in_r,
  output logic [INPUT_WIDTH-2:0]        env
);

  localparam int unsigned EnvWidth = INPUT_WIDTH - 1;

  logic [EnvWidth-1:0] env_q, env_d;
  logic [EnvWidth-1:0] abs_l, abs_r, peak, decayed;

  // Most negative input has no positive twin; clamp it to full scale.
  function automatic logic [EnvWidth-1:0] abs_sat(input logic signed [INPUT_WIDTH-1:0] s);
    if (s == {1'b1, {EnvWidth{1'b0}}}) return '1;
    if (s[INPUT_WIDTH-1]) return EnvWidth'(-s);
    return EnvWidth'(s);
  endfunction

  always_comb begin
    abs_l   = abs_sat(in_l);
    abs_r   = abs_sat(in_r);
    peak    = (abs_l > abs_r) ? abs_l : abs_r;
    decayed = env_q - (env_q >> ENV_SHIFT);
    env_d   = (peak > decayed) ? peak : decayed;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      env_q <= '0;
    end else if (valid) begin
      env_q <= env_d;
    end
  end

  assign env = env_q;

endmodule

// File: rtl/audio_expander.sv
// Downward expander / noise gate with hysteresis, hold time and ramped gain.
// Three-stage pipeline: S1 envelope + input register, S2 gate FSM and gain,
// S3 gain multiply and output register.
//   clk_i, reset_n_i : clock, async active-low reset
//   bus (slave)      : enable_i, sample_valid_i, audio_in_l/r in;
//                      audio_out_l/r, sample_valid_o, gate_open_o, gain_o (Q1.16) out
module audio_expander
  import audio_dyn_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH     = 16,
  parameter int unsigned OUTPUT_WIDTH    = 24,
  parameter int unsigned THRESHOLD_OPEN  = 512,
  parameter int unsigned THRESHOLD_CLOSE = 256,
  parameter int unsigned HOLD_SAMPLES    = 2400,
  parameter int unsigned ATTACK_STEP     = 4096,
  parameter int unsigned RELEASE_STEP    = 64,
  parameter int unsigned FLOOR_GAIN      = 0,
  parameter int unsigned ENV_SHIFT       = 4
) (
  input logic             clk_i,
  input logic             reset_n_i,
  audio_expander_if.slave bus
);

  localparam int unsigned EnvWidth  = INPUT_WIDTH - 1;
  localparam int unsigned ProdWidth = OUTPUT_WIDTH + GAIN_WIDTH;
  localparam int unsigned Shift     = OUTPUT_WIDTH - INPUT_WIDTH;
  localparam int unsigned HoldWidth = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

  localparam logic [GAIN_WIDTH-1:0] GainUnity   = GAIN_WIDTH'(GAIN_UNITY);
  localparam logic [GAIN_WIDTH-1:0] GainFloor   = GAIN_WIDTH'(FLOOR_GAIN);
  localparam logic [GAIN_WIDTH:0]   AttackStep  = (GAIN_WIDTH + 1)'(ATTACK_STEP);
  localparam logic [GAIN_WIDTH:0]   ReleaseStep = (GAIN_WIDTH + 1)'(RELEASE_STEP);
  localparam logic [EnvWidth-1:0]   ThOpen      = EnvWidth'(THRESHOLD_OPEN);
  localparam logic [EnvWidth-1:0]   ThClose     = EnvWidth'(THRESHOLD_CLOSE);

  // S1
  logic                          v1_q;
  logic signed [INPUT_WIDTH-1:0] l1_q, r1_q;
  logic [EnvWidth-1:0]           env1;
  // S2
  logic                          v2_q;
  logic signed [INPUT_WIDTH-1:0] l2_q, r2_q;
  gate_state_t                   state_q, state_d;
  logic [GAIN_WIDTH-1:0]         gain_q, gain_d;
  logic [HoldWidth-1:0]          hold_q, hold_d;
  // S3
  logic                           v3_q;
  logic signed [OUTPUT_WIDTH-1:0] out_l_q, out_r_q;

  logic [GAIN_WIDTH:0]   gain_sum;
  logic [GAIN_WIDTH-1:0] gain_up, gain_dn;

  audio_envelope_peak #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .ENV_SHIFT  (ENV_SHIFT)
  ) u_env (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .valid    (bus.sample_valid_i),
    .in_l     (bus.audio_in_l),
    .in_r     (bus.audio_in_r),
    .env      (env1)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v1_q <= 1'b0;
      l1_q <= '0;
      r1_q <= '0;
    end else begin
      v1_q <= bus.sample_valid_i;
      if (bus.sample_valid_i) begin
        l1_q <= bus.audio_in_l;
        r1_q <= bus.audio_in_r;
      end
    end
  end

  // Ramps saturate at unity on the way up and at the floor on the way down.
  always_comb begin
    gain_sum = {1'b0, gain_q} + AttackStep;
    gain_up  = (gain_sum >= {1'b0, GainUnity}) ? GainUnity : gain_sum[GAIN_WIDTH-1:0];
    gain_dn  = ({1'b0, gain_q} <= {1'b0, GainFloor} + ReleaseStep) ?
               GainFloor : gain_q - ReleaseStep[GAIN_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    if (v1_q) begin
      if (!bus.enable_i) begin
        state_d = OPEN;
        gain_d  = GainUnity;
        hold_d  = '0;
      end else begin
        case (state_q)
          CLOSED: begin
            gain_d = GainFloor;
            // Ramp starts on the sample that crosses the threshold.
            if (env1 >= ThOpen) begin
              gain_d  = gain_up;
              state_d = (gain_up == GainUnity) ? OPEN : OPENING;
            end
          end
          OPENING: begin
            gain_d = gain_up;
            if (gain_up == GainUnity) state_d = OPEN;
          end
          OPEN: begin
            gain_d = GainUnity;
            if (env1 < ThClose) begin
              if (HOLD_SAMPLES == 0) begin
                state_d = CLOSING;
              end else begin
                hold_d  = HoldWidth'(HOLD_SAMPLES);
                state_d = HOLD;
              end
            end
          end
          HOLD: begin
            gain_d = GainUnity;
            if (env1 >= ThClose) begin
              hold_d  = '0;
              state_d = OPEN;
            end else begin
              hold_d = hold_q - 1'b1;
              if (hold_q == HoldWidth'(1)) state_d = CLOSING;
            end
          end
          CLOSING: begin
            if (env1 >= ThOpen) begin
              gain_d  = gain_up;
              state_d = (gain_up == GainUnity) ? OPEN : OPENING;
            end else begin
              gain_d = gain_dn;
              if (gain_dn == GainFloor) state_d = CLOSED;
            end
          end
          default: begin
            state_d = CLOSED;
            gain_d  = GainFloor;
            hold_d  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v2_q    <= 1'b0;
      l2_q    <= '0;
      r2_q    <= '0;
      state_q <= CLOSED;
      gain_q  <= GainFloor;
      hold_q  <= '0;
    end else begin
      v2_q    <= v1_q;
      state_q <= state_d;
      gain_q  <= gain_d;
      hold_q  <= hold_d;
      if (v1_q) begin
        l2_q <= l1_q;
        r2_q <= r1_q;
      end
    end
  end

  // y = sat((sext(s) << Shift) * gain >>> 16); gain zero-extended so sign follows s.
  function automatic logic signed [OUTPUT_WIDTH-1:0] scale(
      input logic signed [INPUT_WIDTH-1:0] s, input logic [GAIN_WIDTH-1:0] g);
    logic signed [OUTPUT_WIDTH-1:0] x;
    logic signed [ProdWidth-1:0]    p;
    x = OUTPUT_WIDTH'(s) <<< Shift;
    p = ProdWidth'(x) * $signed(ProdWidth'(g));
    return OUTPUT_WIDTH'(sat_signed(64'(p >>> GAIN_FRAC), OUTPUT_WIDTH));
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v3_q    <= 1'b0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        out_l_q <= scale(l2_q, gain_q);
        out_r_q <= scale(r2_q, gain_q);
      end
    end
  end

  assign bus.audio_out_l    = out_l_q;
  assign bus.audio_out_r    = out_r_q;
  assign bus.sample_valid_o = v3_q;
  assign bus.gain_o         = gain_q;
  assign bus.gate_open_o    = (state_q inside {OPENING, OPEN, HOLD});

endmodule
